add_accumulate_ctrl: RTL and testbench
======================================

// Module: add_accumulate_ctrl
// PURPOSE
//  Controller for the lab 7.2 add/accumulate datapath. Debounces the ACCUMULATE and CLEAR
//  keys and turns each press into a single-cycle event. Each ACCUMULATE event adds the
//  switch value into a wrapping accumulator; each CLEAR event zeroes it. State is exposed
//  to the NIOS II through an Avalon-MM slave with four registers and a level interrupt.
// PARAMETERS
//  DATA_W          8       switch input width
//  ACC_W           16      accumulator width (ACC_W >= DATA_W, ACC_W <= 24)
//  DEBOUNCE_CYCLES 500000  stable cycles required to accept a key level (10 ms @ 50 MHz)
//  CNT_W           20      debounce counter width; must hold DEBOUNCE_CYCLES-1
// PORTS
//  clk        in  1       system clock; one clock domain
//  reset      in  1       synchronous, active-high reset
//  key_acc_n  in  1       ACCUMULATE key, active-low, asynchronous
//  key_clr_n  in  1       CLEAR key, active-low, asynchronous
//  sw         in  DATA_W  switches; sampled as a quasi-static value
//  address    in  2       Avalon word address
//  chipselect in  1       Avalon select
//  read       in  1       Avalon read strobe
//  write      in  1       Avalon write strobe
//  writedata  in  32      Avalon write data
//  readdata   out 32      Avalon read data, registered
//  irq        out 1       level interrupt = irq_en & pending
//  acc_out    out ACC_W   accumulator value, drives LEDs
// BEHAVIOUR
//  Reset: synchronizer flops = 1 (released). Debouncers = RELEASED, counters 0. acc,
//   snapshot, event_cnt, pending, overflow, irq_en = 0. readdata = 0, irq = 0.
//  Sync: each key passes through 2 flops before the debouncer (2-cycle input latency).
//  Debounce FSM (one per key), counter cleared on every state change:
//   RELEASED     -> PRESS_WAIT when sync = 0.
//   PRESS_WAIT   -> RELEASED if sync = 1; -> PRESSED when cnt = DEBOUNCE_CYCLES-1.
//                   This transition emits a 1-cycle event pulse.
//   PRESSED      -> RELEASE_WAIT when sync = 1.
//   RELEASE_WAIT -> PRESSED if sync = 0 (no pulse); -> RELEASED when cnt = DEBOUNCE_CYCLES-1.
//  Holding a key produces exactly one pulse.
//  ACC pulse: acc <= acc + zext(sw), mod 2^ACC_W. overflow set sticky on carry out.
//   snapshot <= sw. event_cnt (8 bit, wraps) += 1. pending <= 1. All take effect next edge.
//  CLEAR pulse, or CTRL write with bit1 = 1: acc, overflow, event_cnt <= 0.
//   Clear wins over a simultaneous ACC pulse; snapshot and pending are not updated.
//  Registers (unused bits read 0):
//   0 STATUS R/W1C: [0] pending, [1] overflow, [2] acc key debounced-pressed,
//     [3] clr key debounced-pressed, [15:8] event_cnt.
//     Writing 1 to bit 0 or bit 1 clears that bit; a same-cycle set wins over the clear.
//   1 SNAP   R:  [DATA_W-1:0] sw captured at the last accumulate.
//   2 ACC    R:  [ACC_W-1:0] acc.
//   3 CTRL   R/W: [0] irq_en. [1] write-1 clear, self-clearing, always reads 0.
//  Read: readdata <= selected register when chipselect & read, else 0. One-cycle latency,
//   no wait states. Writes act when chipselect & write. Writes to read-only regs are ignored.
//  irq is combinational from registers: it rises the cycle after the pulse edge when irq_en = 1.
// TESTING (bench DEBOUNCE_CYCLES=16, CNT_W=5)
//  1 sw=0x05; key_acc_n bounces 4x at 5-cycle spacing, then held low 40 cycles
//    -> exactly one pulse; acc=0x0005, event_cnt=1, pending=1.
//  2 sw=0xFF; 257 accumulates -> acc=0xFFFF, overflow=0; one more -> acc=0x00FE, overflow=1.
//  3 ACC and CLEAR debounced pulses in the same cycle -> acc=0, overflow=0, event_cnt=0.
//  4 Read addr 2 with acc=0x1234 -> readdata=0x00001234 one cycle after read; 0 otherwise.
//  5 irq_en=1, accumulate -> irq=1; write STATUS=0x1 -> irq=0 next cycle.
//    Repeat with the W1C coinciding with a pulse -> pending stays 1.
//  6 reset asserted in PRESS_WAIT, then key held low 40 cycles
//    -> all registers 0, then exactly one new pulse, acc=sw.

Source files
------------

// File: rtl/add_accumulate_ctrl.sv
// Add/accumulate controller: debounced ACCUMULATE/CLEAR keys drive a wrapping accumulator
// that the processor reads and controls through a four-register Avalon-MM slave with a level irq.

module add_accumulate_ctrl_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_i,
  output logic pulse_o,
  output logic pressed_o
);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter restarts from zero on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    pulse_o = 1'b0;
    case (state_q)
      RELEASED: begin
        if (!sync_i) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (sync_i) begin
          state_d = RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          pulse_o = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (sync_i) state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (!sync_i) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  assign pressed_o = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

endmodule

module add_accumulate_ctrl #(
  parameter int DATA_W          = 8,
  parameter int ACC_W           = 16,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_acc_n,
  input  logic              key_clr_n,
  input  logic [DATA_W-1:0] sw,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [ACC_W-1:0]  acc_out
);

  // Returns {carry, sum} of the accumulator plus the zero-extended switch value.
  function automatic logic [ACC_W:0] add_wrap(input logic [ACC_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    return {1'b0, a} + {{(ACC_W + 1 - DATA_W){1'b0}}, b};
  endfunction

  logic acc_meta_q, acc_sync_q, clr_meta_q, clr_sync_q;
  logic acc_pulse, acc_pressed, clr_pulse, clr_pressed;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] snap_q, snap_d;
  logic [7:0]        evt_q, evt_d;
  logic              pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              irq_en_q, irq_en_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [ACC_W:0]    sum_w;
  logic [31:0]       status_w;
  logic              wr_status, wr_ctrl, clear_req;
  logic              unused_wdata;

  // Keys are asynchronous; released level is 1 so the flops reset high.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_meta_q <= 1'b1;
      acc_sync_q <= 1'b1;
      clr_meta_q <= 1'b1;
      clr_sync_q <= 1'b1;
    end else begin
      acc_meta_q <= key_acc_n;
      acc_sync_q <= acc_meta_q;
      clr_meta_q <= key_clr_n;
      clr_sync_q <= clr_meta_q;
    end
  end

  add_accumulate_ctrl_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_acc (
    .clk      (clk),
    .reset    (reset),
    .sync_i   (acc_sync_q),
    .pulse_o  (acc_pulse),
    .pressed_o(acc_pressed)
  );

  add_accumulate_ctrl_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_clr (
    .clk      (clk),
    .reset    (reset),
    .sync_i   (clr_sync_q),
    .pulse_o  (clr_pulse),
    .pressed_o(clr_pressed)
  );

  assign sum_w     = add_wrap(acc_q, sw);
  assign wr_status = chipselect & write & (address == 2'd0);
  assign wr_ctrl   = chipselect & write & (address == 2'd3);
  assign clear_req = clr_pulse | (wr_ctrl & writedata[1]);
  assign status_w  = {16'h0000, evt_q, 4'h0, clr_pressed, acc_pressed, ovf_q, pend_q};

  assign unused_wdata = ^writedata[31:2];

  // W1C is applied first so that a same-cycle set overrides it.
  always_comb begin
    acc_d    = acc_q;
    snap_d   = snap_q;
    evt_d    = evt_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    irq_en_d = irq_en_q;
    rdata_d  = '0;

    if (wr_status && writedata[0]) pend_d = 1'b0;
    if (wr_status && writedata[1]) ovf_d  = 1'b0;
    if (wr_ctrl) irq_en_d = writedata[0];

    if (clear_req) begin
      acc_d = '0;
      ovf_d = 1'b0;
      evt_d = '0;
    end else if (acc_pulse) begin
      acc_d  = sum_w[ACC_W-1:0];
      if (sum_w[ACC_W]) ovf_d = 1'b1;
      evt_d  = evt_q + 8'd1;
      snap_d = sw;
      pend_d = 1'b1;
    end

    if (chipselect && read) begin
      case (address)
        2'd0:    rdata_d = status_w;
        2'd1:    rdata_d = {{(32 - DATA_W){1'b0}}, snap_q};
        2'd2:    rdata_d = {{(32 - ACC_W){1'b0}}, acc_q};
        default: rdata_d = {31'h0, irq_en_q};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      snap_q   <= '0;
      evt_q    <= '0;
      pend_q   <= 1'b0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      acc_q    <= acc_d;
      snap_q   <= snap_d;
      evt_q    <= evt_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      rdata_q  <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_en_q & pend_q;
  assign acc_out  = acc_q;

endmodule

// File: tb/tb_add_accumulate_ctrl.sv
// Randomised and directed bench for add_accumulate_ctrl, checked every cycle against a
// run-length based behavioural model of the keys and register file.

module tb_add_accumulate_ctrl;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_acc_n = 1'b1;
  logic        key_clr_n = 1'b1;
  logic [7:0]  sw = 8'h00;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic        irq;
  logic [15:0] acc_out;

  int n_checks = 0;
  int n_err = 0;

  add_accumulate_ctrl #(
    .DATA_W(8), .ACC_W(16), .DEBOUNCE_CYCLES(N), .CNT_W(5)
  ) dut (
    .clk(clk), .reset(reset), .key_acc_n(key_acc_n), .key_clr_n(key_clr_n), .sw(sw),
    .address(address), .chipselect(chipselect), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .irq(irq), .acc_out(acc_out)
  );

  always #5 clk = ~clk;

  // Behavioural model: a key is accepted once its synchronised level has been low for
  // N+1 consecutive cycles while released, and released after N+1 consecutive high cycles.
  logic        m_d1a = 1'b1, m_d2a = 1'b1, m_d1c = 1'b1, m_d2c = 1'b1;
  int          m_low_a = 0, m_high_a = 0, m_low_c = 0, m_high_c = 0;
  bit          m_pr_a = 0, m_pr_c = 0;
  logic [15:0] m_acc = '0;
  logic [7:0]  m_evt = '0, m_snap = '0;
  logic        m_ovf = 0, m_pend = 0, m_ien = 0;
  logic [31:0] m_rd = '0;
  int          m_pulses = 0;

  always @(posedge clk) begin : model
    logic sa, sc, pa, pc, clr;
    int sum;
    if (reset) begin
      m_d1a = 1; m_d2a = 1; m_d1c = 1; m_d2c = 1;
      m_low_a = 0; m_high_a = 0; m_low_c = 0; m_high_c = 0;
      m_pr_a = 0; m_pr_c = 0;
      m_acc = '0; m_evt = '0; m_snap = '0; m_ovf = 0; m_pend = 0; m_ien = 0; m_rd = '0;
    end else begin
      sa = m_d2a; m_d2a = m_d1a; m_d1a = key_acc_n;
      sc = m_d2c; m_d2c = m_d1c; m_d1c = key_clr_n;
      if (!sa) begin if (m_low_a < 1000) m_low_a++; m_high_a = 0; end
      else begin if (m_high_a < 1000) m_high_a++; m_low_a = 0; end
      if (!sc) begin if (m_low_c < 1000) m_low_c++; m_high_c = 0; end
      else begin if (m_high_c < 1000) m_high_c++; m_low_c = 0; end
      pa = !m_pr_a && (m_low_a == N + 1);
      pc = !m_pr_c && (m_low_c == N + 1);

      m_rd = '0;
      if (chipselect && read) begin
        case (address)
          2'd0: m_rd = {16'h0, m_evt, 4'h0, m_pr_c, m_pr_a, m_ovf, m_pend};
          2'd1: m_rd = {24'h0, m_snap};
          2'd2: m_rd = {16'h0, m_acc};
          default: m_rd = {31'h0, m_ien};
        endcase
      end

      if (pa) m_pr_a = 1; else if (m_pr_a && m_high_a == N + 1) m_pr_a = 0;
      if (pc) m_pr_c = 1; else if (m_pr_c && m_high_c == N + 1) m_pr_c = 0;

      clr = pc || (chipselect && write && address == 2'd3 && writedata[1]);
      if (chipselect && write && address == 2'd0) begin
        if (writedata[0]) m_pend = 0;
        if (writedata[1]) m_ovf = 0;
      end
      if (chipselect && write && address == 2'd3) m_ien = writedata[0];
      if (clr) begin
        m_acc = '0; m_ovf = 0; m_evt = '0;
      end else if (pa) begin
        sum = m_acc + sw;
        if (sum > 65535) m_ovf = 1;
        m_acc = sum[15:0];
        m_evt = m_evt + 8'd1;
        m_snap = sw;
        m_pend = 1;
        m_pulses++;
      end
    end
  end

  function automatic bit pulse_next_a();
    return !reset && !m_pr_a && (m_d2a == 1'b0) && (m_low_a == N);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : compare
    @(posedge clk);
    forever begin
      #1;
      check("acc_out", {16'h0, acc_out}, {16'h0, m_acc});
      check("irq", {31'h0, irq}, {31'h0, m_ien & m_pend});
      check("readdata", readdata, m_rd);
      @(posedge clk);
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1; write = 1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 0; write = 0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1; read = 1; address = a;
    @(negedge clk);
    chipselect = 0; read = 0;
    d = readdata;
  endtask

  task automatic acc_press(input logic [7:0] v, input int lo, input int hi);
    @(negedge clk);
    sw = v; key_acc_n = 0;
    wait_n(lo);
    key_acc_n = 1;
    wait_n(hi);
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0] d;
    int p0;
    bit hit;

    wait_n(3);
    reset = 0;
    check("reset acc_out", {16'h0, acc_out}, 32'h0);
    check("reset irq", {31'h0, irq}, 32'h0);
    check("reset readdata", readdata, 32'h0);

    // Bouncing key then a steady hold: one pulse only
    sw = 8'h05;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); key_acc_n = 0; wait_n(4);
      @(negedge clk); key_acc_n = 1; wait_n(4);
    end
    @(negedge clk); key_acc_n = 0;
    wait_n(40);
    bus_read(2'd0, d);
    check("s1 status", d, 32'h0000_0105);
    check("s1 acc", {16'h0, acc_out}, 32'h5);
    key_acc_n = 1;
    wait_n(25);

    // Wrap and sticky overflow
    bus_write(2'd3, 32'h2);
    for (int i = 0; i < 257; i++) acc_press(8'hFF, 22, 22);
    check("s2 acc ffff", {16'h0, acc_out}, 32'hFFFF);
    bus_read(2'd0, d);
    check("s2 status before wrap", d, 32'h0000_0101);
    acc_press(8'hFF, 22, 22);
    check("s2 acc wrapped", {16'h0, acc_out}, 32'h00FE);
    bus_read(2'd0, d);
    check("s2 status after wrap", d, 32'h0000_0203);

    // Simultaneous ACC and CLEAR presses: clear wins
    @(negedge clk); sw = 8'h33; key_acc_n = 0; key_clr_n = 0;
    wait_n(22);
    key_acc_n = 1; key_clr_n = 1;
    wait_n(22);
    check("s3 acc", {16'h0, acc_out}, 32'h0);
    bus_read(2'd0, d);
    check("s3 status", d, 32'h0000_0001);

    // Read of ACC with a registered one-cycle latency
    bus_write(2'd3, 32'h2);
    for (int i = 0; i < 18; i++) acc_press(8'hFF, 22, 22);
    acc_press(8'h46, 22, 22);
    bus_read(2'd2, d);
    check("s4 read acc", d, 32'h0000_1234);
    @(negedge clk);
    check("s4 readdata idle", readdata, 32'h0);
    bus_read(2'd1, d);
    check("s4 read snap", d, 32'h0000_0046);

    // Interrupt enable, W1C, and W1C colliding with a set
    bus_write(2'd3, 32'h1);
    bus_write(2'd0, 32'h1);
    check("s5 irq cleared", {31'h0, irq}, 32'h0);
    acc_press(8'h01, 22, 22);
    check("s5 irq raised", {31'h0, irq}, 32'h1);
    bus_write(2'd0, 32'h1);
    check("s5 irq after w1c", {31'h0, irq}, 32'h0);
    @(negedge clk); key_acc_n = 0;
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      if (pulse_next_a()) begin
        chipselect = 1; write = 1; address = 2'd0; writedata = 32'h1; hit = 1;
      end
    end
    @(negedge clk); chipselect = 0; write = 0;
    check("s5 pulse found", {31'h0, hit}, 32'h1);
    check("s5 set beats w1c", {31'h0, irq}, 32'h1);
    key_acc_n = 1;
    wait_n(22);

    // Reset while a press is being qualified
    @(negedge clk); sw = 8'h5A; key_acc_n = 0;
    wait_n(8);
    reset = 1;
    wait_n(2);
    check("s6 reset acc", {16'h0, acc_out}, 32'h0);
    check("s6 reset irq", {31'h0, irq}, 32'h0);
    reset = 0;
    p0 = m_pulses;
    wait_n(40);
    check("s6 one pulse", m_pulses - p0, 32'd1);
    check("s6 acc", {16'h0, acc_out}, 32'h005A);
    bus_read(2'd0, d);
    check("s6 status", d, 32'h0000_0105);
    key_acc_n = 1;
    wait_n(25);

    // Random traffic on keys, switches and bus
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) key_acc_n = ~key_acc_n;
      if ($urandom_range(0, 13) == 0) key_clr_n = ~key_clr_n;
      if ($urandom_range(0, 19) == 0) sw = 8'($urandom);
      chipselect = ($urandom_range(0, 3) != 0);
      read = ($urandom_range(0, 2) == 0);
      write = ($urandom_range(0, 7) == 0);
      address = 2'($urandom);
      writedata = $urandom;
    end
    @(negedge clk);
    chipselect = 0; read = 0; write = 0; key_acc_n = 1; key_clr_n = 1;
    wait_n(30);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
